serial_rx_controller: RTL and testbench
=======================================

Name: serial_rx_controller

Overview:
- Control FSM that sequences the serial-receive datapath (port shift register, length shift register, length down-counter, output demux).
- Converts the raw push-button step input into a one-cycle step pulse.
- Tracks the frame phases (start bit, port field, length field, data field) and issues per-step shift/decrement enables and the valid strobe.
- Sits between the board inputs and the existing datapath; the datapath keeps all data registers and reports only the down-counter's zero flag back.

Parameters:
- PORT_W, 2, width of the port-address field in bits.
- LEN_W, 4, width of the length field in bits; the datapath down-counter has the same width.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_pb  input  1  raw push-button step request; asynchronous, level.
- ser_in  input  1  serial data bit; asynchronous, level.
- cnt_zero  input  1  datapath length down-counter equals 0.
- step  output  1  one-cycle pulse per clk_pb rising edge (datapath shift clock enable).
- ser_bit  output  1  synchronized ser_in, aligned with step.
- shift_port_en  output  1  shift ser_bit into the port register this cycle.
- shift_len_en  output  1  shift ser_bit into the length register/counter this cycle.
- cnt_dec_en  output  1  decrement the length counter this cycle.
- valid  output  1  data phase active; ser_bit is being routed to the selected port.
- busy  output  1  frame in progress (state != IDLE).
- state_o  output  3  current state encoding, for debug/display.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bit counter=0, all sync flops=0. All outputs are 0; state_o=IDLE code.
- Sync: clk_pb and ser_in each pass through 2 flops. A third flop holds the previous clk_pb_s.
  - step = clk_pb_s & ~clk_pb_d (combinational).
  - step is high exactly 1 cycle, 2–3 clocks after the raw rise.
  - Holding clk_pb high produces no further pulses.
- ser_bit = synchronized ser_in, so it is sampled in the same cycle as step.
- Internal bit counter: width clog2(max(PORT_W,LEN_W))+1. Cleared on every state transition.
- States (encoding lives in the package): IDLE=0, PORT=1, LEN=2, DATA=3, DONE=4.
- IDLE:
  - step & ser_bit==0 (start bit) -> PORT.
  - step & ser_bit==1 is ignored; stay in IDLE.
- PORT:
  - On each step: shift_port_en=1 and bit counter +1.
  - On the step where counter==PORT_W-1 -> LEN.
- LEN:
  - On each step: shift_len_en=1 and bit counter +1.
  - On the step where counter==LEN_W-1 -> DATA.
- DATA:
  - valid = ~cnt_zero (combinational).
  - step & ~cnt_zero: cnt_dec_en=1, stay in DATA.
  - cnt_zero=1 (no step needed) -> DONE next clock.
  - Length 0: DATA lasts 1 cycle, valid never asserts.
- DONE: 1-cycle state; -> IDLE unconditionally. No enables asserted.
- Enable outputs are Mealy: each is high only in the cycle step is high, so at most one enable is high per cycle. busy=1 in PORT, LEN, DATA and DONE.
- Step arriving in DONE: dropped; it is not a start bit.
- Reset mid-frame: immediate return to IDLE; partial fields are discarded and the datapath registers are not touched. The frame restarts at the next start bit.
- Illegal state codes (5–7) -> IDLE on the next clock.

Decomposition:
- Package serial_rx_pkg holds:
  - state enum/localparams IDLE..DONE, 3-bit;
  - default PORT_W and LEN_W constants.
- One sub-module, one_pulser: 2-flop synchronizer plus edge detector, producing step from clk_pb.
  - ser_in gets an identical 2-flop sync inside the controller, so the two synchronized signals are aligned.

Test Plan:
- Reset: pulse reset low mid-clock -> all outputs 0 immediately, state_o=0; each clk_pb press afterwards gives exactly one 1-cycle step.
- Idle noise: 3 presses with ser_in=1 -> state stays IDLE, no enable ever high, busy=0.
- Full frame: bits 0,1,1,0,1,0,1 (start, port=11, len=0101), model counter loads 5:
  - 2 shift_port_en pulses, then 4 shift_len_en pulses;
  - then 5 presses give 5 cnt_dec_en pulses with valid=1;
  - cnt_zero -> DONE -> IDLE; valid falls in the cycle cnt_zero rises.
- Zero length: start, port=01, len=0000 -> DATA for 1 cycle, valid never 1, IDLE 2 clocks after the last len step; extra presses produce no cnt_dec_en.
- Reset mid-frame: abort after 2 length bits -> IDLE; next frame 0,0,0,0,0,1,0 (port=00, len=0010) runs correctly with exactly 2 valid steps.
- Long press: hold clk_pb high for 50 clocks during PORT -> a single shift_port_en pulse only.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared constants and state encoding for the serial-receive controller.
package serial_rx_pkg;

  localparam int unsigned PORT_W_DEF = 2;
  localparam int unsigned LEN_W_DEF  = 4;
  localparam int unsigned STATE_W    = 3;

  // Frame phases; codes are exported on state_o for the board display.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PORT = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_DONE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/one_pulser.sv
// Two-flop synchronizer plus rising-edge detector: one clock-wide pulse per press.
module one_pulser (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Synchronize the raw level and keep one cycle of history for the edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pb_i};
      prev_q <= sync_q[1];
    end
  end

  assign pulse_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/serial_rx_controller.sv
// Control FSM sequencing the serial-receive datapath: start bit, port field,
// length field, then data steps until the datapath down-counter reaches zero.
module serial_rx_controller
  import serial_rx_pkg::*;
#(
  parameter int unsigned PORT_W = PORT_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clk_pb,
  input  logic               ser_in,
  input  logic               cnt_zero,
  output logic               step,
  output logic               ser_bit,
  output logic               shift_port_en,
  output logic               shift_len_en,
  output logic               cnt_dec_en,
  output logic               valid,
  output logic               busy,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned FIELD_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
  localparam int unsigned BCNT_W    = $clog2(FIELD_MAX) + 1;
  localparam logic [BCNT_W-1:0] PORT_LAST = BCNT_W'(PORT_W - 1);
  localparam logic [BCNT_W-1:0] LEN_LAST  = BCNT_W'(LEN_W - 1);

  rx_state_e         state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [1:0]        ser_sync_q;

  // Step pulse from the push button.
  one_pulser u_step (
    .clk     (clock),
    .rst_n   (reset),
    .pb_i    (clk_pb),
    .pulse_o (step)
  );

  // Same two-flop depth as the step path so ser_bit lines up with step.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ser_sync_q <= '0;
    end else begin
      ser_sync_q <= {ser_sync_q[0], ser_in};
    end
  end

  assign ser_bit = ser_sync_q[1];

  // State and field bit counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state and Mealy enables; enables only fire in a step cycle.
  always_comb begin
    state_d       = state_q;
    bcnt_d        = bcnt_q;
    shift_port_en = 1'b0;
    shift_len_en  = 1'b0;
    cnt_dec_en    = 1'b0;
    valid         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (step && !ser_bit) state_d = ST_PORT;
      end
      ST_PORT: begin
        if (step) begin
          shift_port_en = 1'b1;
          bcnt_d        = bcnt_q + BCNT_W'(1);
          if (bcnt_q == PORT_LAST) state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (step) begin
          shift_len_en = 1'b1;
          bcnt_d       = bcnt_q + BCNT_W'(1);
          if (bcnt_q == LEN_LAST) state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        valid = ~cnt_zero;
        if (cnt_zero)  state_d    = ST_DONE;
        else if (step) cnt_dec_en = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Each phase counts its own field from zero.
    if (state_d != state_q) bcnt_d = '0;
  end

  assign busy    = (state_q != ST_IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_serial_rx_controller.sv
// Randomized bench for serial_rx_controller with a frame-level reference model
// and a small behavioural length counter standing in for the datapath.
module tb_serial_rx_controller;

  localparam int P = 2;
  localparam int L = 4;
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_DONE  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clk_pb = 1'b0;
  logic       ser_in = 1'b0;
  logic       cnt_zero;
  logic       step, ser_bit, shift_port_en, shift_len_en, cnt_dec_en, valid, busy;
  logic [2:0] state_o;

  serial_rx_controller #(.PORT_W(P), .LEN_W(L)) dut (
    .clock         (clock),
    .reset         (reset),
    .clk_pb        (clk_pb),
    .ser_in        (ser_in),
    .cnt_zero      (cnt_zero),
    .step          (step),
    .ser_bit       (ser_bit),
    .shift_port_en (shift_port_en),
    .shift_len_en  (shift_len_en),
    .cnt_dec_en    (cnt_dec_en),
    .valid         (valid),
    .busy          (busy),
    .state_o       (state_o)
  );

  always #5 clock = ~clock;

  // Datapath stand-in: length shift register doubling as the down-counter.
  logic [3:0] cnt = 4'd0;
  logic [3:0] cnt_nxt = 4'd0;
  assign cnt_zero = (cnt == 4'd0);
  always @(posedge clock) cnt <= cnt_nxt;

  int n_cmp = 0;
  int n_err = 0;
  int c_step = 0, c_port = 0, c_len = 0, c_dec = 0, c_vstep = 0, c_busy = 0;

  // Reference model: raw input history as seen at the last three edges,
  // plus frame progress as a count of field bits taken since the start bit.
  bit pb_h [3];
  bit ser_h [3];
  int mode = M_IDLE;
  int nbits = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_ser_bit"}, int'(ser_bit), 0);
    chk({tag, "_port_en"}, int'(shift_port_en), 0);
    chk({tag, "_len_en"}, int'(shift_len_en), 0);
    chk({tag, "_dec_en"}, int'(cnt_dec_en), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_state"}, int'(state_o), 0);
  endtask

  // Per-cycle compare against the model, then advance the model one clock.
  always @(negedge clock) begin
    int e_step, e_ser, e_st, e_port, e_len, e_dec, e_valid, e_busy;
    cnt_nxt = cnt;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        pb_h[i]  = 1'b0;
        ser_h[i] = 1'b0;
      end
      mode  = M_IDLE;
      nbits = 0;
      chk_all_zero("in_reset");
    end else begin
      e_step  = int'(pb_h[1] & ~pb_h[2]);
      e_ser   = int'(ser_h[1]);
      e_port  = 0;
      e_len   = 0;
      e_dec   = 0;
      e_valid = 0;
      if (mode == M_IDLE)       e_st = 0;
      else if (mode == M_DONE)  e_st = 4;
      else if (nbits < P)       begin e_st = 1; e_port = e_step; end
      else if (nbits < P + L)   begin e_st = 2; e_len  = e_step; end
      else begin
        e_st    = 3;
        e_valid = int'(!cnt_zero);
        e_dec   = (e_step != 0 && !cnt_zero) ? 1 : 0;
      end
      e_busy = (mode != M_IDLE) ? 1 : 0;

      chk("step", int'(step), e_step);
      chk("ser_bit", int'(ser_bit), e_ser);
      chk("state_o", int'(state_o), e_st);
      chk("shift_port_en", int'(shift_port_en), e_port);
      chk("shift_len_en", int'(shift_len_en), e_len);
      chk("cnt_dec_en", int'(cnt_dec_en), e_dec);
      chk("valid", int'(valid), e_valid);
      chk("busy", int'(busy), e_busy);

      c_step  += int'(step);
      c_port  += int'(shift_port_en);
      c_len   += int'(shift_len_en);
      c_dec   += int'(cnt_dec_en);
      c_vstep += int'(valid & step);
      c_busy  += int'(busy);

      case (mode)
        M_IDLE:  if (e_step != 0 && e_ser == 0) begin mode = M_FRAME; nbits = 0; end
        M_FRAME: begin
          if (nbits < P + L) begin
            if (e_step != 0) nbits++;
          end else if (cnt_zero) begin
            mode = M_DONE;
          end
        end
        default: mode = M_IDLE;
      endcase

      if (shift_len_en)    cnt_nxt = {cnt[2:0], ser_bit};
      else if (cnt_dec_en) cnt_nxt = cnt - 4'd1;

      pb_h[2]  = pb_h[1];
      pb_h[1]  = pb_h[0];
      pb_h[0]  = clk_pb;
      ser_h[2] = ser_h[1];
      ser_h[1] = ser_h[0];
      ser_h[0] = ser_in;
    end
  end

  // Stimulus helpers; each leaves time at 2 units after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic press(input bit b, input int hold, input int gap);
    ser_in = b;
    clk_pb = 1'b1;
    cyc(hold);
    clk_pb = 1'b0;
    cyc(gap);
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) press(w[n-1-i], 1, 4);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (state_o != 3'd0 && k < 100) begin
      cyc(1);
      k++;
    end
    chk("wait_idle", int'(state_o), 0);
  endtask

  task automatic mid_reset(input string tag);
    #1 reset = 1'b0;
    #1 chk_all_zero(tag);
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    int s_step, s_port, s_len, s_dec, s_vstep, s_busy;
    int plen, pbits;
    #1 chk_all_zero("por");
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // Asynchronous reset in idle, then single pulse per press.
    mid_reset("idle_rst");
    for (int i = 0; i < 2; i++) begin
      s_step = c_step;
      press(1'b1, 3, 5);
      chk("one_step_per_press", c_step - s_step, 1);
    end

    // Presses with ser_in high are not start bits.
    s_port = c_port; s_len = c_len; s_dec = c_dec; s_busy = c_busy;
    for (int i = 0; i < 3; i++) press(1'b1, 2, 4);
    chk("noise_port", c_port - s_port, 0);
    chk("noise_len", c_len - s_len, 0);
    chk("noise_dec", c_dec - s_dec, 0);
    chk("noise_busy", c_busy - s_busy, 0);

    // Full frame: port 11, length 0101.
    s_port = c_port; s_len = c_len; s_dec = c_dec; s_vstep = c_vstep;
    send_word(16'b0110101, 7);
    chk("full_port_pulses", c_port - s_port, 2);
    chk("full_len_pulses", c_len - s_len, 4);
    chk("full_len_loaded", int'(cnt), 5);
    chk("full_in_data", int'(state_o), 3);
    for (int i = 0; i < 5; i++) press(1'($urandom_range(1)), 1, 4);
    wait_idle();
    chk("full_dec_pulses", c_dec - s_dec, 5);
    chk("full_valid_steps", c_vstep - s_vstep, 5);
    chk("full_cnt_end", int'(cnt), 0);

    // Zero length frame.
    s_vstep = c_vstep; s_dec = c_dec;
    send_word(16'b0010000, 7);
    chk("zero_back_idle", int'(state_o), 0);
    press(1'b1, 1, 4);
    press(1'b1, 1, 4);
    chk("zero_valid_steps", c_vstep - s_vstep, 0);
    chk("zero_dec_pulses", c_dec - s_dec, 0);

    // Reset mid-frame after two length bits, then a fresh frame.
    send_word(16'b01011, 5);
    chk("abort_in_len", int'(state_o), 2);
    mid_reset("frame_rst");
    s_vstep = c_vstep; s_dec = c_dec;
    send_word(16'b0000010, 7);
    chk("restart_len_loaded", int'(cnt), 2);
    press(1'b1, 1, 4);
    press(1'b0, 1, 4);
    wait_idle();
    chk("restart_valid_steps", c_vstep - s_vstep, 2);
    chk("restart_dec_pulses", c_dec - s_dec, 2);

    // Long press during the port field.
    send_word(16'b0, 1);
    s_port = c_port; s_vstep = c_vstep;
    press(1'b1, 50, 4);
    chk("long_port_pulses", c_port - s_port, 1);
    send_word(16'b00001, 5);
    press(1'b0, 1, 4);
    wait_idle();
    chk("long_valid_steps", c_vstep - s_vstep, 1);

    // Randomized frames with random timing and idle noise.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(2) == 0) press(1'b1, $urandom_range(3, 1), $urandom_range(4, 1));
      plen  = $urandom_range(6);
      pbits = $urandom_range(3);
      s_vstep = c_vstep;
      press(1'b0, $urandom_range(3, 1), $urandom_range(5, 1));
      for (int i = 0; i < P; i++)
        press(pbits[P-1-i], $urandom_range(3, 1), $urandom_range(5, 1));
      for (int i = 0; i < L; i++)
        press(plen[L-1-i], $urandom_range(3, 1), $urandom_range(5, 1));
      cyc(2);
      for (int i = 0; i < plen; i++)
        press(1'($urandom_range(1)), $urandom_range(3, 1), $urandom_range(5, 1));
      wait_idle();
      chk("rand_valid_steps", c_vstep - s_vstep, plen);
    end

    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
